// File: rtl/io_pkg.sv
// Shared types and constants for the human-input port blocks.
package io_pkg;

  // Debounce FSM states: stable low, confirming a rise, stable high, confirming a fall.
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } db_state_t;

  localparam int IO_WIDTH = 8;

endpackage

// File: rtl/switch_input_port_debounce.sv
// Two-flop synchronizer plus debounce FSM for one push-button.
// The level changes only after DB_CYCLES consecutive samples agree.
// rise strobes for one cycle on the RISE_WAIT -> HIGH transition.
module debounce
  import io_pkg::*;
#(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES);
  // The edge that would push the count to DB_CYCLES is the one that commits the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             btn_p0;
  logic             btn_p1;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Saturating increment so a long stable level can never wrap the counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Synchronize the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= btn_raw;
      btn_p1 <= btn_p0;
    end
  end

  // State and stability counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter update and rise strobe.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise      = 1'b0;
    case (state)
      LOW: begin
        if (btn_p1) begin
          state_nxt = RISE_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      RISE_WAIT: begin
        if (!btn_p1) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          rise      = 1'b1;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      HIGH: begin
        if (!btn_p1) begin
          state_nxt = FALL_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      FALL_WAIT: begin
        if (btn_p1) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Level is a pure decode of the state register, so no input reaches it combinationally.
  assign level = (state == HIGH) || (state == FALL_WAIT);

endmodule

// File: rtl/switch_input_port.sv
// Switch bank and push-button input port for the CPU datapath.
// Each debounced press samples the synchronized switches into a
// valid/ack holding register; presses dropped while full set a sticky overrun.
module switch_input_port
  import io_pkg::*;
#(
  parameter int WIDTH     = IO_WIDTH,
  parameter int DB_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             btn_raw,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun,
  output logic             btn_level
);

  logic [WIDTH-1:0] sw_p0;
  logic [WIDTH-1:0] sw_p1;
  logic             press;

  debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .level   (btn_level),
    .rise    (press)
  );

  // Synchronize the asynchronous switch bank; switches are quasi-static so per-bit sync suffices.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= sw_raw;
      sw_p1 <= sw_p0;
    end
  end

  // Capture on press, consume on ack; ack on the press edge means consume-then-capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (press) begin
      if (!valid || rd_ack) begin
        data  <= sw_p1;
        valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rd_ack && valid) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port with DB_CYCLES = 4 (press commits 6 edges after drive).
module tb_switch_input_port;

  localparam int WIDTH = 8;
  localparam int DBC   = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] sw_raw;
  logic             btn_raw;
  logic             rd_ack;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             overrun;
  logic             btn_level;

  int total;
  int bad;
  logic [WIDTH-1:0] exp_q[$];

  switch_input_port #(
    .WIDTH     (WIDTH),
    .DB_CYCLES (DBC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .btn_raw   (btn_raw),
    .rd_ack    (rd_ack),
    .data      (data),
    .valid     (valid),
    .overrun   (overrun),
    .btn_level (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the next expected capture; an empty queue is itself a failed comparison.
  task automatic check_capture(input string tag);
    logic [WIDTH-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%0h expected=<queue empty>", tag, data);
    end else begin
      e = exp_q.pop_front();
      total--;
      check(tag, {24'h0, data}, {24'h0, e});
    end
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_bad;
    total    = 0;
    bad      = 0;
    sw_raw   = '0;
    btn_raw  = 1'b0;
    rd_ack   = 1'b0;
    rst      = 1'b1;
    #2 rst   = 1'b0;
    #1;
    check("rst_data", {24'h0, data}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_level", {31'h0, btn_level}, 32'h0);
    tick(2);
    rst = 1'b1;
    tick(3);

    // Clean press with A5
    sw_raw  = 8'hA5;
    exp_q.push_back(8'hA5);
    btn_raw = 1'b1;
    tick(5);
    check("clean_pre_valid", {31'h0, valid}, 32'h0);
    check("clean_pre_level", {31'h0, btn_level}, 32'h0);
    tick(1);
    check("clean_valid", {31'h0, valid}, 32'h1);
    check_capture("clean_data");
    check("clean_level", {31'h0, btn_level}, 32'h1);
    pulse_ack();
    check("clean_ack_valid", {31'h0, valid}, 32'h0);

    // Release debounce
    btn_raw = 1'b0;
    tick(5);
    check("rel_level_hold", {31'h0, btn_level}, 32'h1);
    tick(1);
    check("rel_level_fall", {31'h0, btn_level}, 32'h0);
    check("rel_valid", {31'h0, valid}, 32'h0);
    check("rel_data", {24'h0, data}, 32'hA5);
    tick(2);

    // Bounce 1,1,1,0 for 40 cycles
    sw_raw   = 8'h5A;
    seen_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      btn_raw = ((i % 4) != 3);
      tick(1);
      if (valid !== 1'b0 || btn_level !== 1'b0) seen_bad = 1'b1;
    end
    btn_raw = 1'b0;
    tick(4);
    check("bounce_quiet", {31'h0, seen_bad}, 32'h0);
    check("bounce_data", {24'h0, data}, 32'hA5);

    // Overrun: 11 held, 22 dropped
    sw_raw = 8'h11;
    exp_q.push_back(8'h11);
    btn_raw = 1'b1;
    tick(6);
    check("ovr_first_valid", {31'h0, valid}, 32'h1);
    check_capture("ovr_first_data");
    btn_raw = 1'b0;
    tick(8);
    sw_raw  = 8'h22;
    btn_raw = 1'b1;
    tick(6);
    check("ovr_data", {24'h0, data}, 32'h11);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    check("ovr_valid", {31'h0, valid}, 32'h1);
    pulse_ack();
    check("ovr_ack_valid", {31'h0, valid}, 32'h0);
    check("ovr_ack_flag", {31'h0, overrun}, 32'h0);
    btn_raw = 1'b0;
    tick(8);

    // Simultaneous ack and press
    sw_raw = 8'h44;
    exp_q.push_back(8'h44);
    btn_raw = 1'b1;
    tick(6);
    check_capture("sim_first_data");
    btn_raw = 1'b0;
    tick(8);
    sw_raw = 8'h33;
    exp_q.push_back(8'h33);
    btn_raw = 1'b1;
    tick(5);
    pulse_ack();
    check_capture("sim_data");
    check("sim_valid", {31'h0, valid}, 32'h1);
    check("sim_overrun", {31'h0, overrun}, 32'h0);
    pulse_ack();
    check("sim_ack_valid", {31'h0, valid}, 32'h0);
    btn_raw = 1'b0;
    tick(8);

    // Leave a pending value, then reset mid-debounce
    sw_raw = 8'h66;
    btn_raw = 1'b1;
    tick(6);
    check("rmd_pending", {31'h0, valid}, 32'h1);
    btn_raw = 1'b0;
    tick(8);
    sw_raw  = 8'h55;
    btn_raw = 1'b1;
    tick(4);
    rst = 1'b0;
    #1;
    check("rmd_data", {24'h0, data}, 32'h0);
    check("rmd_valid", {31'h0, valid}, 32'h0);
    check("rmd_overrun", {31'h0, overrun}, 32'h0);
    check("rmd_level", {31'h0, btn_level}, 32'h0);
    tick(3);
    check("rmd_hold_valid", {31'h0, valid}, 32'h0);
    rst = 1'b1;
    exp_q.push_back(8'h55);
    tick(5);
    check("rmd_pre_valid", {31'h0, valid}, 32'h0);
    tick(1);
    check("rmd_valid_after", {31'h0, valid}, 32'h1);
    check_capture("rmd_capture");
    tick(10);
    check("rmd_single_press", {31'h0, overrun}, 32'h0);
    check("rmd_level_high", {31'h0, btn_level}, 32'h1);
    check("rmd_queue_empty", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
